// File: rtl/change_dispenser_ctrl.sv
// Coin-return sequencer: pays a change amount greedily in 10/5/1 coins taken
// from a tracked inventory, one coin per ejector handshake, with saturating refills.
module change_dispenser_ctrl #(
    parameter int unsigned W       = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned INIT_10 = 20,
    parameter int unsigned INIT_5  = 20,
    parameter int unsigned INIT_1  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [W-1:0]     req_amount,
    output logic             req_ready,
    output logic             coin_valid,
    output logic [3:0]       coin_value,
    input  logic             coin_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_sel,
    input  logic [CNT_W-1:0] refill_count,
    output logic [CNT_W-1:0] inv_10,
    output logic [CNT_W-1:0] inv_5,
    output logic [CNT_W-1:0] inv_1,
    output logic [W-1:0]     remaining,
    output logic             done,
    output logic             short,
    output logic [2:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the source holds valid and payload stable until then. Requests
    // use req_valid/req_ready; coins use coin_valid with coin_ack as the ready.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_OFFER  = 3'd2,
        S_DONE   = 3'd3,
        S_SHORT  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [W-1:0]     rem, rem_n;
    logic             settle, settle_n;
    logic             req_ready_n;
    logic             coin_valid_n;
    logic [3:0]       coin_value_n;
    logic             done_n;
    logic             short_n;
    logic             ack_fire;
    logic             take_10, take_5, take_1;
    logic             add_10, add_5, add_1;
    logic [CNT_W-1:0] inv_10_n, inv_5_n, inv_1_n;

    // Net inventory change for one denomination; the sum can exceed the
    // counter range, so it is formed one bit wider and clamped to all-ones.
    function automatic logic [CNT_W-1:0] inv_update(
        input logic [CNT_W-1:0] cur,
        input logic             take,
        input logic             add,
        input logic [CNT_W-1:0] cnt
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} - {{CNT_W{1'b0}}, take}
            + (add ? {1'b0, cnt} : {(CNT_W+1){1'b0}});
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign ack_fire = (state == S_OFFER) && coin_valid && coin_ack;
    assign take_10  = ack_fire && (coin_value == 4'd10);
    assign take_5   = ack_fire && (coin_value == 4'd5);
    assign take_1   = ack_fire && (coin_value == 4'd1);

    assign add_10   = refill_valid && (refill_sel == 2'b11);
    assign add_5    = refill_valid && (refill_sel == 2'b10);
    assign add_1    = refill_valid && (refill_sel == 2'b01);

    assign inv_10_n = inv_update(inv_10, take_10, add_10, refill_count);
    assign inv_5_n  = inv_update(inv_5,  take_5,  add_5,  refill_count);
    assign inv_1_n  = inv_update(inv_1,  take_1,  add_1,  refill_count);

    always_comb begin
        state_n      = state;
        rem_n        = rem;
        settle_n     = settle;
        coin_valid_n = coin_valid;
        coin_value_n = coin_value;
        done_n       = 1'b0;
        short_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    rem_n    = req_amount;
                    settle_n = 1'b1;
                    state_n  = S_SELECT;
                end
            end
            S_SELECT: begin
                // The first SELECT after a request only settles, giving the
                // vending FSM a fixed two-edge request-to-first-output latency.
                if (settle) begin
                    settle_n = 1'b0;
                end else if (rem == '0) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else if (rem >= W'(10) && inv_10 != '0) begin
                    coin_valid_n = 1'b1;
                    coin_value_n = 4'd10;
                    state_n      = S_OFFER;
                end else if (rem >= W'(5) && inv_5 != '0) begin
                    coin_valid_n = 1'b1;
                    coin_value_n = 4'd5;
                    state_n      = S_OFFER;
                end else if (inv_1 != '0) begin
                    coin_valid_n = 1'b1;
                    coin_value_n = 4'd1;
                    state_n      = S_OFFER;
                end else begin
                    short_n = 1'b1;
                    state_n = S_SHORT;
                end
            end
            S_OFFER: begin
                if (ack_fire) begin
                    rem_n        = rem - W'(coin_value);
                    coin_valid_n = 1'b0;
                    coin_value_n = 4'd0;
                    state_n      = S_SELECT;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_SHORT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        req_ready_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            rem        <= '0;
            settle     <= 1'b0;
            req_ready  <= 1'b1;
            coin_valid <= 1'b0;
            coin_value <= 4'd0;
            done       <= 1'b0;
            short      <= 1'b0;
            inv_10     <= CNT_W'(INIT_10);
            inv_5      <= CNT_W'(INIT_5);
            inv_1      <= CNT_W'(INIT_1);
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            settle     <= settle_n;
            req_ready  <= req_ready_n;
            coin_valid <= coin_valid_n;
            coin_value <= coin_value_n;
            done       <= done_n;
            short      <= short_n;
            inv_10     <= inv_10_n;
            inv_5      <= inv_5_n;
            inv_1      <= inv_1_n;
        end
    end

    assign remaining = rem;
    assign state_dbg = state;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Scoreboard bench for change_dispenser_ctrl: a greedy reference model fills an
// expected queue of coins and end events; a monitor thread pops and compares.
`timescale 1ns/1ps
module tb_change_dispenser_ctrl;

    localparam int W     = 32;
    localparam int CNT_W = 8;
    localparam logic [31:0] T_COIN  = 32'h1000_0000;
    localparam logic [31:0] T_DONE  = 32'h2000_0000;
    localparam logic [31:0] T_SHORT = 32'h3000_0000;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic [W-1:0]     req_amount = '0;
    logic             req_ready;
    logic             coin_valid;
    logic [3:0]       coin_value;
    logic             coin_ack;
    logic             refill_valid = 1'b0;
    logic [1:0]       refill_sel = 2'b00;
    logic [CNT_W-1:0] refill_count = '0;
    logic [CNT_W-1:0] inv_10, inv_5, inv_1;
    logic [W-1:0]     remaining;
    logic             done, short;
    logic [2:0]       state_dbg;

    always #5 clk = ~clk;

    // ack_mode: 0 = held low, 1 = tied high, 2 = random per cycle, 3 = manual
    logic [1:0] ack_mode = 2'd1;
    logic       ack_rand = 1'b0;
    logic       ack_manual = 1'b0;
    assign coin_ack = (ack_mode == 2'd0) ? 1'b0 :
                      (ack_mode == 2'd1) ? 1'b1 :
                      (ack_mode == 2'd2) ? ack_rand : ack_manual;

    change_dispenser_ctrl #(
        .W(W), .CNT_W(CNT_W), .INIT_10(20), .INIT_5(20), .INIT_1(20)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ack(coin_ack),
        .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_count(refill_count),
        .inv_10(inv_10), .inv_5(inv_5), .inv_1(inv_1),
        .remaining(remaining), .done(done), .short(short), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state / reference model ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int term_count = 0;
    int term_base = 0;
    int exp_rem = 0;
    int inv_m[3];
    int denom[3] = '{10, 5, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got 'h%0h expected nothing (queue empty) at %0t", name, act, $time);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    function automatic int sel_idx(input logic [1:0] s);
        case (s)
            2'b11:   return 0;
            2'b10:   return 1;
            2'b01:   return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int k = 0; k < 3; k++) inv_m[k] = 20;
    endtask

    // ---------------- monitor / ack driver threads ----------------
    task automatic run_monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                if (coin_valid && coin_ack) sb_pop("coin", T_COIN | 32'(coin_value));
                if (done) begin
                    sb_pop("done", T_DONE | remaining);
                    term_count++;
                end
                if (short) begin
                    sb_pop("short", T_SHORT | remaining);
                    term_count++;
                end
                if (!coin_valid) check("coin_value_idle", 32'(coin_value), 0);
            end
        end
    endtask

    task automatic run_ack();
        forever begin
            @(posedge clk);
            #1 ack_rand = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic refill(input logic [1:0] sel, input int cnt);
        int k;
        refill_valid = 1'b1;
        refill_sel   = sel;
        refill_count = CNT_W'(cnt);
        @(posedge clk); #1;
        refill_valid = 1'b0;
        k = sel_idx(sel);
        if (k >= 0) inv_m[k] = sat_add(inv_m[k], cnt);
    endtask

    task automatic issue_req(input int amt);
        int r, n, budget;
        r = amt;
        for (int k = 0; k < 3; k++) begin
            n = r / denom[k];
            if (n > inv_m[k]) n = inv_m[k];
            for (int c = 0; c < n; c++) exp_q.push_back(T_COIN | 32'(denom[k]));
            inv_m[k] -= n;
            r -= n * denom[k];
        end
        exp_rem = r;
        exp_q.push_back(r == 0 ? T_DONE : (T_SHORT | 32'(r)));
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("req_ready_idle", 32'(req_ready), 1);
        term_base  = term_count;
        req_valid  = 1'b1;
        req_amount = W'(amt);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_amount = $urandom;
        @(posedge clk); #1;
        check("latency_quiet_n1", 32'(coin_valid | done | short), 0);
        @(posedge clk); #1;
        check("latency_active_n2", 32'(coin_valid | done | short), 1);
    endtask

    task automatic wait_term();
        int budget;
        budget = 0;
        while (term_count == term_base && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        check("end_event_seen", 32'(term_count != term_base), 1);
    endtask

    task automatic check_inv();
        check("inv_10", 32'(inv_10), 32'(inv_m[0]));
        check("inv_5",  32'(inv_5),  32'(inv_m[1]));
        check("inv_1",  32'(inv_1),  32'(inv_m[2]));
    endtask

    task automatic do_req(input int amt);
        issue_req(amt);
        wait_term();
        check("remaining", remaining, 32'(exp_rem));
        check_inv();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        fork
            run_monitor();
            run_ack();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst_coin_valid", 32'(coin_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_short", 32'(short), 0);
        check("rst_remaining", remaining, 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check_inv();
        @(posedge clk); #1;
        check("rst_req_ready_after", 32'(req_ready), 1);

        // 6 with ack tied high: 5 then 1
        ack_mode = 2'd1;
        do_req(6);

        // Drain tens to one, then 26: 10,5,5,5,1
        apply_reset();
        do_req(190);
        do_req(26);

        // Empty fives and ones, then 3 must fall short
        do_req(85);
        do_req(19);
        do_req(3);
        repeat (3) @(posedge clk);
        #1;
        check("short_remaining_held", remaining, 3);
        check("short_req_ready", 32'(req_ready), 1);

        // Zero amount: done with no coins
        do_req(0);

        // Ack held low: offer stays stable, requests ignored
        apply_reset();
        ack_mode   = 2'd3;
        ack_manual = 1'b0;
        issue_req(10);
        for (int i = 0; i < 5; i++) begin
            req_valid  = (i < 2);
            req_amount = 99;
            @(posedge clk); #1;
            check("hold_coin_valid", 32'(coin_valid), 1);
            check("hold_coin_value", 32'(coin_value), 10);
            check("hold_no_done", 32'(done), 0);
            check("hold_req_ready", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        // Ack and a 10-dollar refill of 4 on the same edge
        ack_manual   = 1'b1;
        refill_valid = 1'b1;
        refill_sel   = 2'b11;
        refill_count = 8'd4;
        @(posedge clk); #1;
        ack_manual   = 1'b0;
        refill_valid = 1'b0;
        inv_m[0]     = sat_add(inv_m[0], 4);
        wait_term();
        check("hold_remaining", remaining, 0);
        check_inv();
        check("inv_10_after_concurrent", 32'(inv_10), 23);
        refill(2'b11, 250);
        check_inv();
        check("inv_10_saturated", 32'(inv_10), 255);

        // Reset while a 10 is on offer
        apply_reset();
        ack_mode   = 2'd3;
        ack_manual = 1'b0;
        issue_req(10);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check("midrst_coin_valid", 32'(coin_valid), 0);
        check("midrst_req_ready", 32'(req_ready), 1);
        check("midrst_remaining", remaining, 0);
        check_inv();
        reset      = 1'b1;
        ack_manual = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ack_manual = 1'b0;
        check("stray_ack_coin_valid", 32'(coin_valid), 0);
        check("stray_ack_req_ready", 32'(req_ready), 1);
        check_inv();

        // Randomized transactions with random ack and idle-time refills
        apply_reset();
        ack_mode = 2'd2;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0)
                refill(2'($urandom_range(0, 3)), $urandom_range(0, 30));
            if ($urandom_range(0, 7) == 0) do_req($urandom_range(0, 300));
            else                           do_req($urandom_range(0, 60));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
